serial_subtractor_n: RTL and testbench
======================================

Name: serial_subtractor_n

Overview:
- Bit-serial N-bit subtractor: the inverse operation of the team's parameterized combinational full adder.
- Computes diff = a - b - bi, LSB first, one bit per clock, and produces a borrow-out.
- Used where area matters more than latency; it sits behind a start/done handshake so arithmetic datapaths can reuse one borrow stage for all N bits.

Parameters:
- N, 8, operand and result width in bits (N >= 1).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request pulse; sampled on a rising edge of clk.
- a  input  N  minuend; captured when start is accepted.
- b  input  N  subtrahend; captured when start is accepted.
- bi  input  1  borrow-in; captured when start is accepted.
- busy  output  1  high while a subtraction is in progress.
- done  output  1  single-cycle pulse; high when diff/bo become valid.
- diff  output  N  result a - b - bi, modulo 2^N.
- bo  output  1  borrow-out; 1 when a < b + bi (unsigned).

Behaviour:
- Reset: synchronous, active-high. On any clk edge with rst=1:
  - state -> IDLE;
  - busy=0, done=0, diff=0, bo=0;
  - internal shift registers, borrow and bit counter cleared.
  - rst has priority over start.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - busy=0, done=0; diff/bo hold the last result.
  - On start=1: load a, b into shift registers, borrow <= bi, counter <= 0; go to SHIFT.
- SHIFT (busy=1), per cycle on bit0 of each shift register (a0, b0):
  - d = a0 ^ b0 ^ br;
  - br_next = (~a0 & b0) | (~(a0 ^ b0) & br);
  - d is shifted into the result register at the MSB, result shifted right;
  - a and b shift right; counter increments.
  - After the N-th bit (counter == N-1), go to DONE.
- DONE:
  - done=1 and busy=0 for exactly one cycle.
  - diff = result register; bo = final borrow.
  - Next state is IDLE, unless start=1 in this cycle, in which case new operands load and the next state is SHIFT (back-to-back).
- Latency: start accepted at edge t; SHIFT occupies edges t+1..t+N; done is high during the cycle after edge t+N and falls at edge t+N+1.
  - Throughput: one result per N+1 cycles.
- start while in SHIFT is ignored: no effect on operands, counter or result.
- diff and bo change only at DONE entry or on reset; they are stable between results.
- Reset mid-SHIFT aborts the operation; no done pulse is produced for the aborted operation.
- N=1: a single SHIFT cycle, then DONE.
- Arithmetic is unsigned modulo 2^N. Signed overflow is not reported.
- Counter width is ceil(log2(N)) (minimum 1).

Test Plan:
- N=8, a=8'h05, b=8'h03, bi=0, single start pulse -> done pulses exactly 9 cycles after the start edge; diff=8'h02, bo=0; busy high for 8 cycles.
- N=8, a=8'h00, b=8'h01, bi=0 -> diff=8'hFF, bo=1. Then a=8'h00, b=8'h00, bi=1 -> diff=8'hFF, bo=1. Then a=8'hFF, b=8'hFF, bi=1 -> diff=8'hFF, bo=1.
- Start during SHIFT:
  - start a=8'h10, b=8'h01;
  - pulse start with a=8'hAA, b=8'h55 at cycle 4;
  - required: result is diff=8'h0F, bo=0, with only one done pulse.
- Reset mid-operation:
  - start a=8'h80, b=8'h01;
  - assert rst at cycle 3;
  - required: next cycle busy=0, done=0, diff=0, bo=0, and no done pulse follows;
  - a fresh start then completes normally.
- Back-to-back:
  - hold start=1 in the DONE cycle with a=8'h20, b=8'h10;
  - required: busy rises the next cycle, the first result is held until the second done, and the second result is diff=8'h10, bo=0 after N+1 more cycles.
- N=1 sweep: all 8 combinations of a, b, bi -> diff/bo match the truth table (e.g. a=0, b=1, bi=1 -> diff=0, bo=1); done arrives 2 cycles after each start.

Source files
------------

// File: rtl/serial_subtractor_n.sv
// Bit-serial N-bit subtractor: diff = a - b - bi computed LSB first, one bit per clock,
// behind a start/busy/done handshake with a registered result and borrow-out.
module serial_subtractor_n #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         bi,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] diff,
  output logic         bo
);
  // Handshake: start is accepted on a rising edge while in IDLE or DONE; it is
  // ignored during SHIFT. done is high for exactly one cycle when diff/bo update,
  // and diff/bo then hold until the next done or a reset.
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t         state;
  logic [N-1:0]   a_sr;
  logic [N-1:0]   b_sr;
  logic [N-1:0]   res_sr;
  logic           br;
  logic [CW-1:0]  cnt;

  logic           a0;
  logic           b0;
  logic           d;
  logic           br_next;
  logic [N:0]     res_cat;
  logic [N-1:0]   res_next;

  always_comb begin
    a0       = a_sr[0];
    b0       = b_sr[0];
    d        = a0 ^ b0 ^ br;
    br_next  = (~a0 & b0) | (~(a0 ^ b0) & br);
    // Concatenate then drop the LSB so the shift also works for N = 1.
    res_cat  = {d, res_sr};
    res_next = res_cat[N:1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      a_sr   <= '0;
      b_sr   <= '0;
      res_sr <= '0;
      br     <= 1'b0;
      cnt    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      diff   <= '0;
      bo     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            a_sr   <= a;
            b_sr   <= b;
            br     <= bi;
            res_sr <= '0;
            cnt    <= '0;
            busy   <= 1'b1;
            state  <= SHIFT;
          end else begin
            state  <= IDLE;
          end
        end
        SHIFT: begin
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          res_sr <= res_next;
          br     <= br_next;
          cnt    <= cnt + CW'(1);
          if (cnt == CW'(N - 1)) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            diff  <= res_next;
            bo    <= br_next;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_serial_subtractor_n.sv
// Directed bench for serial_subtractor_n: an N=8 instance driven from a vector table
// plus corner-case sequences, and an N=1 instance swept over its full truth table.
module tb_serial_subtractor_n;
  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] a;
  logic [7:0] b;
  logic       bi;
  logic       busy8;
  logic       done8;
  logic [7:0] diff8;
  logic       bo8;

  logic       start1;
  logic [0:0] a1;
  logic [0:0] b1;
  logic       bi1;
  logic       busy1;
  logic       done1;
  logic [0:0] diff1;
  logic       bo1;

  int vectors;
  int miscompares;

  logic [8:0] exp_q[$];
  logic [8:0] mon_exp;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       bi;
    logic [7:0] diff;
    logic       bo;
  } vec_t;

  vec_t vecs[9];

  serial_subtractor_n #(.N(8)) dut8 (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .bi(bi),
    .busy(busy8), .done(done8), .diff(diff8), .bo(bo8)
  );

  serial_subtractor_n #(.N(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .bi(bi1),
    .busy(busy1), .done(done1), .diff(diff1), .bo(bo1)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: every done pulse of the N=8 instance must match the oldest expected result.
  always @(posedge clk) begin
    #1;
    if (done8) begin
      if (exp_q.size() == 0) begin
        check("spurious_done", {31'b0, done8}, 32'h0);
      end else begin
        mon_exp = exp_q.pop_front();
        check("result", {23'b0, bo8, diff8}, {23'b0, mon_exp});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run8(input logic [7:0] ta, input logic [7:0] tb_v, input logic tbi,
                      input logic [7:0] ed, input logic eb);
    int cyc;
    int busy_cnt;
    a = ta; b = tb_v; bi = tbi; start = 1'b1;
    exp_q.push_back({eb, ed});
    tick();
    start = 1'b0;
    cyc = 1;
    busy_cnt = busy8 ? 1 : 0;
    while (!done8 && cyc < 30) begin
      tick();
      cyc++;
      if (busy8) busy_cnt++;
    end
    check("latency", cyc, 9);
    check("busy_cycles", busy_cnt, 8);
    check("busy_at_done", {31'b0, busy8}, 32'h0);
    tick();
    check("done_width", {31'b0, done8}, 32'h0);
    check("hold_after_done", {23'b0, bo8, diff8}, {23'b0, eb, ed});
  endtask

  initial begin
    int cyc;
    int val;
    logic [7:0] ed;
    logic       eb;
    vectors = 0;
    miscompares = 0;
    rst = 1'b1; start = 1'b0; a = '0; b = '0; bi = 1'b0;
    start1 = 1'b0; a1 = '0; b1 = '0; bi1 = 1'b0;

    vecs[0] = '{8'h05, 8'h03, 1'b0, 8'h02, 1'b0};
    vecs[1] = '{8'h00, 8'h01, 1'b0, 8'hFF, 1'b1};
    vecs[2] = '{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1};
    vecs[3] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
    vecs[4] = '{8'h10, 8'h01, 1'b0, 8'h0F, 1'b0};
    vecs[5] = '{8'h80, 8'h01, 1'b0, 8'h7F, 1'b0};
    vecs[6] = '{8'hAA, 8'h55, 1'b0, 8'h55, 1'b0};
    vecs[7] = '{8'h55, 8'hAA, 1'b1, 8'hAA, 1'b1};
    vecs[8] = '{8'hFF, 8'h00, 1'b0, 8'hFF, 1'b0};

    repeat (2) tick();
    check("rst_busy", {31'b0, busy8}, 32'h0);
    check("rst_done", {31'b0, done8}, 32'h0);
    check("rst_diff", {24'b0, diff8}, 32'h0);
    check("rst_bo", {31'b0, bo8}, 32'h0);
    check("rst_busy_n1", {31'b0, busy1}, 32'h0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 9; i++) begin
      run8(vecs[i].a, vecs[i].b, vecs[i].bi, vecs[i].diff, vecs[i].bo);
    end

    // start during SHIFT must be ignored
    a = 8'h10; b = 8'h01; bi = 1'b0; start = 1'b1;
    exp_q.push_back({1'b0, 8'h0F});
    tick();
    start = 1'b0;
    repeat (3) tick();
    a = 8'hAA; b = 8'h55; start = 1'b1;
    tick();
    start = 1'b0;
    cyc = 0;
    while (!done8 && cyc < 30) begin tick(); cyc++; end
    check("ignore_start_done_seen", {31'b0, done8}, 32'h1);
    repeat (14) tick();
    check("ignore_start_idle", {31'b0, busy8}, 32'h0);
    check("ignore_start_queue", exp_q.size(), 0);

    // reset mid-SHIFT aborts without a done pulse
    a = 8'h80; b = 8'h01; bi = 1'b0; start = 1'b1;
    exp_q.push_back({1'b0, 8'h7F});
    tick();
    start = 1'b0;
    repeat (2) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_q.delete();
    check("abort_busy", {31'b0, busy8}, 32'h0);
    check("abort_done", {31'b0, done8}, 32'h0);
    check("abort_diff", {24'b0, diff8}, 32'h0);
    check("abort_bo", {31'b0, bo8}, 32'h0);
    repeat (12) tick();
    check("abort_stays_idle", {31'b0, busy8}, 32'h0);
    run8(8'h80, 8'h01, 1'b0, 8'h7F, 1'b0);

    // back-to-back: start held in the DONE cycle
    a = 8'h05; b = 8'h03; bi = 1'b0; start = 1'b1;
    exp_q.push_back({1'b0, 8'h02});
    tick();
    start = 1'b0;
    cyc = 0;
    while (!done8 && cyc < 30) begin tick(); cyc++; end
    check("b2b_first_done", {31'b0, done8}, 32'h1);
    a = 8'h20; b = 8'h10; bi = 1'b0; start = 1'b1;
    exp_q.push_back({1'b0, 8'h10});
    tick();
    start = 1'b0;
    check("b2b_busy_rises", {31'b0, busy8}, 32'h1);
    check("b2b_done_low", {31'b0, done8}, 32'h0);
    cyc = 1;
    while (!done8 && cyc < 30) begin
      check("b2b_hold", {23'b0, bo8, diff8}, {23'b0, 1'b0, 8'h02});
      tick();
      cyc++;
    end
    check("b2b_latency", cyc, 9);
    tick();
    check("b2b_queue_empty", exp_q.size(), 0);

    // N=1 truth-table sweep
    for (int i = 0; i < 8; i++) begin
      a1 = i[2]; b1 = i[1]; bi1 = i[0];
      val = int'(i[2]) - int'(i[1]) - int'(i[0]);
      ed = 8'(val & 1);
      eb = (val < 0);
      start1 = 1'b1;
      tick();
      start1 = 1'b0;
      cyc = 1;
      while (!done1 && cyc < 10) begin tick(); cyc++; end
      check("n1_latency", cyc, 2);
      check("n1_diff", {31'b0, diff1}, {31'b0, ed[0]});
      check("n1_bo", {31'b0, bo1}, {31'b0, eb});
      tick();
    end

    repeat (2) tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
